// File: rtl/fetch_decode.sv
// Front end of the 8-bit datapath: PC, instruction fetch over req/ack,
// instruction register, opcode decode and local branch/jump resolution.
module fetch_decode #(
    parameter int unsigned         PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [15:0]         imem_rdata,
    input  logic [3:0]          ALUflags,
    input  logic                exec_ready,
    output logic [15:0]         INS,
    output logic [1:0]          ALUctrl,
    output logic                reg_we,
    output logic                ins_valid,
    output logic                halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_HALTED
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_BEQ  = 3'b100,
        OP_JMP  = 3'b101,
        OP_NOP  = 3'b110,
        OP_HALT = 3'b111
    } opcode_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [15:0]         ins_q, ins_d;
    logic [1:0]          aluctrl_q, aluctrl_d;

    opcode_t             opcode;
    logic [PC_WIDTH-1:0] pc_plus1;
    logic [PC_WIDTH-1:0] br_off;
    logic [PC_WIDTH-1:0] jmp_tgt;
    logic                flags_unused;

    assign opcode   = opcode_t'(ins_q[15:13]);
    assign pc_plus1 = pc_q + PC_WIDTH'(1);
    assign br_off   = PC_WIDTH'(signed'(ins_q[7:0]));
    assign jmp_tgt  = PC_WIDTH'(ins_q[7:0]);

    // Only the Z flag steers branches; the others belong to later opcodes.
    assign flags_unused = ^{ALUflags[3], ALUflags[1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            ins_q     <= '0;
            aluctrl_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed by the next-state logic.
            state_q   <= state_d;
            pc_q      <= pc_d;
            ins_q     <= ins_d;
            aluctrl_q <= aluctrl_d;
        end
    end

    always_comb begin
        // NOTE: hold-current defaults cover every path, so no latches.
        state_d   = state_q;
        pc_d      = pc_q;
        ins_d     = ins_q;
        aluctrl_d = aluctrl_q;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ack) begin
                    ins_d   = imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        aluctrl_d = ins_q[14:13];
                        state_d   = S_ISSUE;
                    end
                    OP_BEQ: begin
                        pc_d    = ALUflags[2] ? (pc_plus1 + br_off) : pc_plus1;
                        state_d = S_FETCH;
                    end
                    OP_JMP: begin
                        pc_d    = jmp_tgt;
                        state_d = S_FETCH;
                    end
                    OP_NOP: begin
                        pc_d    = pc_plus1;
                        state_d = S_FETCH;
                    end
                    OP_HALT: state_d = S_HALTED;
                endcase
            end
            S_ISSUE: begin
                if (exec_ready) begin
                    pc_d    = pc_plus1;
                    state_d = S_FETCH;
                end
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    // Handshake/status outputs decode straight from state so reset drops them at once.
    always_comb begin
        imem_req  = (state_q == S_FETCH);
        ins_valid = (state_q == S_ISSUE);
        reg_we    = (state_q == S_ISSUE);
        halted    = (state_q == S_HALTED);
    end

    assign imem_addr = pc_q;
    assign INS       = ins_q;
    assign ALUctrl   = aluctrl_q;

endmodule

// File: tb/tb_fetch_decode.sv
// Scoreboard bench for fetch_decode: expected fetch addresses and issued
// instructions are queued per program and matched as the DUT produces them.
module tb_fetch_decode;

    localparam int PW = 8;
    localparam logic [PW-1:0] RST_PC = 8'h00;
    localparam logic [15:0] HALT_W = 16'hE000;
    localparam logic [15:0] NOP_W  = 16'hC000;

    typedef struct {
        logic [15:0] ins;
        logic [1:0]  alu;
        int          stall;
    } issue_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          imem_req;
    logic [PW-1:0] imem_addr;
    logic          imem_ack;
    logic [15:0]   imem_rdata;
    logic [3:0]    ALUflags;
    logic          exec_ready;
    logic [15:0]   INS;
    logic [1:0]    ALUctrl;
    logic          reg_we;
    logic          ins_valid;
    logic          halted;

    always #5 clk = ~clk;

    fetch_decode #(.PC_WIDTH(PW), .RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ALUflags   (ALUflags),
        .exec_ready (exec_ready),
        .INS        (INS),
        .ALUctrl    (ALUctrl),
        .reg_we     (reg_we),
        .ins_valid  (ins_valid),
        .halted     (halted)
    );

    logic [PW-1:0] exp_fetch_q[$];
    issue_t        exp_issue_q[$];
    logic [15:0]   mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    bit            req_seen;
    bit            iss_seen;
    logic [PW-1:0] req_addr;
    logic [15:0]   req_ins;
    issue_t        cur_iss;
    int            iss_len;
    int            stall_left;
    int            wait_cnt;
    logic [PW-1:0] slow_addr;
    int            slow_delay;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe outputs on the falling edge, then drive memory/execute responses.
    task automatic tick();
        @(negedge clk);
        if (imem_req) begin
            if (!req_seen) begin
                req_seen = 1'b1;
                req_addr = imem_addr;
                req_ins  = INS;
                check("fetch_pending", exp_fetch_q.size() > 0, 1);
                if (exp_fetch_q.size() > 0) check("fetch_addr", imem_addr, exp_fetch_q.pop_front());
            end else begin
                check("fetch_addr_stable", imem_addr, req_addr);
                check("ins_hold_in_fetch", INS, req_ins);
            end
        end else begin
            req_seen = 1'b0;
        end

        if (ins_valid) begin
            check("reg_we_valid", reg_we, 1);
            if (!iss_seen) begin
                iss_seen = 1'b1;
                iss_len  = 1;
                check("issue_pending", exp_issue_q.size() > 0, 1);
                if (exp_issue_q.size() > 0) cur_iss = exp_issue_q.pop_front();
                else cur_iss = '{ins: 16'h0000, alu: 2'b00, stall: 0};
                stall_left = cur_iss.stall;
            end else begin
                iss_len++;
            end
            check("issue_ins", INS, cur_iss.ins);
            check("issue_aluctrl", ALUctrl, cur_iss.alu);
        end else begin
            check("reg_we_idle", reg_we, 0);
            if (iss_seen) begin
                iss_seen = 1'b0;
                check("issue_len", iss_len, cur_iss.stall + 1);
            end
        end

        if (imem_req) begin
            if (wait_cnt >= ((imem_addr == slow_addr) ? slow_delay : 0)) begin
                imem_ack   = 1'b1;
                imem_rdata = mem[imem_addr];
                wait_cnt   = 0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = 16'hDEAD;
                wait_cnt++;
            end
        end else begin
            imem_ack = 1'b0;
            wait_cnt = 0;
        end

        if (ins_valid && stall_left > 0) begin
            exec_ready = 1'b0;
            stall_left--;
        end else begin
            exec_ready = 1'b1;
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = HALT_W;
    endtask

    // Reset is asserted mid-cycle so its asynchronous effect is observable before any edge.
    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_imem_req", imem_req, 0);
        check("rst_ins_valid", ins_valid, 0);
        check("rst_reg_we", reg_we, 0);
        check("rst_halted", halted, 0);
        check("rst_ins", INS, 16'h0000);
        check("rst_aluctrl", ALUctrl, 2'b00);
        check("rst_pc", imem_addr, RST_PC);
        req_seen   = 1'b0;
        iss_seen   = 1'b0;
        stall_left = 0;
        wait_cnt   = 0;
        slow_delay = 0;
        slow_addr  = '0;
        imem_ack   = 1'b0;
        exec_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_fetch_q.size() > 0 || exp_issue_q.size() > 0 || iss_seen) && n < budget) begin
            tick();
            n++;
        end
        check("drain_in_budget", n < budget, 1);
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic expect_halted();
        check("halted", halted, 1);
        check("halted_no_req", imem_req, 0);
        check("halted_no_valid", ins_valid, 0);
    endtask

    initial begin
        reset      = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        ALUflags   = 4'h0;
        exec_ready = 1'b1;
        clear_mem();

        // Single ADD then HALT.
        mem[0] = 16'h0A90;
        exp_fetch_q = '{8'd0, 8'd1};
        exp_issue_q.push_back('{ins: 16'h0A90, alu: 2'b00, stall: 0});
        do_reset();
        drain(50);
        settle(3);
        expect_halted();

        // NOPs, then SUB at address 3 with a 4-cycle ack delay.
        clear_mem();
        mem[0] = NOP_W; mem[1] = NOP_W; mem[2] = NOP_W;
        mem[3] = 16'h2E50;
        exp_fetch_q = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4};
        exp_issue_q.push_back('{ins: 16'h2E50, alu: 2'b01, stall: 0});
        do_reset();
        slow_addr  = 8'd3;
        slow_delay = 4;
        drain(80);
        settle(3);
        expect_halted();

        // AND stalled by exec_ready for 3 cycles, then OR.
        clear_mem();
        mem[0] = 16'h4530;
        mem[1] = 16'h7C60;
        exp_fetch_q = '{8'd0, 8'd1, 8'd2};
        exp_issue_q.push_back('{ins: 16'h4530, alu: 2'b10, stall: 3});
        exp_issue_q.push_back('{ins: 16'h7C60, alu: 2'b11, stall: 0});
        do_reset();
        drain(80);
        settle(3);
        expect_halted();

        // BEQ at 10, offset -4: taken with Z=1, then not taken with Z=0.
        for (int z = 1; z >= 0; z--) begin
            clear_mem();
            mem[0]  = 16'hA00A;
            mem[10] = 16'h80FC;
            ALUflags = (z == 1) ? 4'b0100 : 4'b1011;
            exp_fetch_q = '{8'd0, 8'd10, (z == 1) ? 8'd7 : 8'd11};
            do_reset();
            drain(50);
            settle(3);
            expect_halted();
        end

        // JMP 0x40.
        clear_mem();
        mem[0] = 16'hA040;
        exp_fetch_q = '{8'd0, 8'h40};
        do_reset();
        drain(50);
        settle(3);
        expect_halted();

        // Backward branch below 0 wraps to 0xFF; NOP at 0xFF wraps to 0x00.
        clear_mem();
        mem[0]    = 16'h80FE;
        mem[8'hFF] = NOP_W;
        ALUflags  = 4'b0100;
        exp_fetch_q = '{8'd0, 8'hFF};
        do_reset();
        drain(50);
        mem[0] = HALT_W;
        exp_fetch_q.push_back(8'h00);
        drain(50);
        settle(3);
        expect_halted();

        // HALT at 5 stays stopped for 20 cycles; reset restarts at RESET_PC.
        clear_mem();
        for (int i = 0; i < 5; i++) mem[i] = NOP_W;
        exp_fetch_q = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
        do_reset();
        drain(60);
        settle(3);
        begin
            int req_cnt = 0;
            int halt_cnt = 0;
            for (int i = 0; i < 20; i++) begin
                tick();
                req_cnt  += int'(imem_req);
                halt_cnt += int'(halted);
            end
            check("halt_req_20", req_cnt, 0);
            check("halt_hold_20", halt_cnt, 20);
        end
        clear_mem();
        exp_fetch_q = '{RST_PC};
        do_reset();
        check("halt_cleared", halted, 0);
        drain(20);
        settle(3);
        expect_halted();

        // Reset during an ISSUE stall aborts the issue; nothing re-issued after release.
        clear_mem();
        mem[0] = 16'h0A90;
        exp_fetch_q = '{8'd0};
        exp_issue_q.push_back('{ins: 16'h0A90, alu: 2'b00, stall: 10});
        do_reset();
        begin
            int n = 0;
            while (!iss_seen && n < 20) begin
                tick();
                n++;
            end
            check("stall_issue_seen", iss_seen, 1);
        end
        settle(2);
        check("stall_valid_held", ins_valid, 1);
        mem[0] = HALT_W;
        exp_fetch_q = '{RST_PC};
        do_reset();
        drain(20);
        settle(3);
        expect_halted();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_decode.md
Name: fetch_decode

Overview:
- Upstream front end of the 8-bit datapath.
- Holds the program counter and fetches 16-bit instruction words from instruction memory over a req/ack handshake.
- Latches each word into an instruction register and decodes the opcode into the ALU control and register-write enable that the register-file/ALU execute stage consumes.
- Resolves branches and jumps locally using the execute stage's ALU flags, and stops on HALT.

Parameters:
PC_WIDTH, 8, width of program counter and instruction memory address
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
imem_req  output  1  fetch request, held high until acknowledged
imem_addr  output  PC_WIDTH  fetch address, equals PC while imem_req=1
imem_ack  input  1  instruction memory has imem_rdata valid this cycle
imem_rdata  input  16  instruction word
ALUflags  input  4  flags from execute stage: [3]=N, [2]=Z, [1]=C, [0]=V
exec_ready  input  1  execute stage accepts the issued instruction this cycle
INS  output  16  latched instruction register; fields [15:13] opcode, [12:10] dest reg, [9:7] src A, [6:4] src B, [7:0] branch/jump target
ALUctrl  output  2  ALU operation for the issued instruction
reg_we  output  1  register-file write enable, high only while ins_valid=1
ins_valid  output  1  INS/ALUctrl/reg_we are a valid ALU instruction
halted  output  1  core stopped on HALT

Behaviour:
- Reset (async, any state): all outputs forced to their reset values.
  - PC=RESET_PC, INS=16'h0000, ALUctrl=0, reg_we=0, ins_valid=0, imem_req=0, halted=0.
  - State=IDLE.
- States: IDLE, FETCH, DECODE, ISSUE, HALTED.
- IDLE: exactly one cycle after reset deasserts, then FETCH.
- FETCH: imem_req=1, imem_addr=PC.
  - On imem_ack=1: INS<=imem_rdata, go to DECODE.
  - Otherwise remain; imem_req and imem_addr stay stable.
  - imem_ack sampled in any other state is ignored.
- DECODE: one cycle, opcode=INS[15:13].
  - 000 ADD, 001 SUB, 010 AND, 011 OR: ALUctrl<=opcode[1:0], go to ISSUE.
  - 100 BEQ: if ALUflags[2]=1 (flags sampled this cycle), PC<=PC+1+sign-extended INS[7:0]; else PC<=PC+1. Go to FETCH.
  - 101 JMP: PC<=INS[7:0] (zero-extended/truncated to PC_WIDTH). Go to FETCH.
  - 110 NOP: PC<=PC+1, go to FETCH.
  - 111 HALT: go to HALTED; PC unchanged.
- ISSUE: ins_valid=1, reg_we=1; INS and ALUctrl held stable.
  - On exec_ready=1: handshake completes; PC<=PC+1, ins_valid/reg_we drop next cycle, go to FETCH.
  - On exec_ready=0: stall, all outputs held.
- HALTED: halted=1, imem_req=0, ins_valid=0. Exits only on reset.
- PC arithmetic is modulo 2^PC_WIDTH: 8'hFF+1 wraps to 8'h00; backward branch below 0 wraps likewise.
- Throughput with imem_ack and exec_ready tied high:
  - ALU instruction: 3 cycles (FETCH, DECODE, ISSUE).
  - Branch/jump/NOP: 2 cycles.
- Latency: ack in cycle t -> INS valid at t+1, ins_valid asserted at t+2.
- Branch and ISSUE never occur in the same cycle, so flags are always those of the previously completed ALU op.
- Reset asserted mid-handshake (FETCH or ISSUE) aborts it immediately; nothing is re-issued after release.

Test Plan:
- Reset release, memory acks every request, mem[0]=16'h0A90 (ADD r2,r5,r1), exec_ready=1 -> imem_addr=0 with imem_req; ins_valid pulses 1 cycle with ALUctrl=00, reg_we=1, INS=16'h0A90; next fetch address 1.
- imem_ack delayed 4 cycles on address 3 -> imem_req and imem_addr=3 stable for all 4 cycles; INS updates only after ack.
- ISSUE with exec_ready low 3 cycles -> ins_valid, reg_we, ALUctrl, INS held; PC increments once, only after exec_ready=1.
- BEQ at PC=10 with INS[7:0]=8'hFC: Z=1 -> next fetch 7; Z=0 -> next fetch 11. JMP 8'h40 -> next fetch 0x40. NOP at 8'hFF -> next fetch 0x00.
- HALT (16'hE000) at PC=5 -> halted=1, imem_req stays 0 for 20 cycles; reset -> halted=0, fetch restarts at RESET_PC.
- Reset asserted during ISSUE stall -> ins_valid/reg_we drop asynchronously, PC=RESET_PC; after release the first fetch is address RESET_PC.
